fetch_decode_queue: RTL
=======================

Name: fetch_decode_queue

Overview:
- Parametrised, DEPTH-entry instruction queue that replaces the single fetch-to-decode pipeline register.
- Each entry is one fetch packet: instr, pc, pcPlus4 and bPredictedTaken.
- Uses a valid/ready handshake, so fetch keeps running while decode stalls.
- A flush from branch resolution empties the queue in one cycle.
- The head entry drives decode directly; decode pops the head when it accepts it.

Parameters:
- XLEN, 32: width of instr, pc and pcPlus4.
- DEPTH, 4: number of entries; must be a power of two and at least 2.
- PTRW, $clog2(DEPTH): index width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries, including any push in the same cycle.
- inValid  in  1  fetch presents a packet.
- inReady  out  1  queue can accept a packet; equals !full.
- instrF  in  XLEN  fetched instruction.
- pcF  in  XLEN  pc of the fetched instruction.
- pcPlus4F  in  XLEN  pc+4 of the fetched instruction.
- bPredictedTakenF  in  1  predictor decision for this packet.
- outValid  out  1  head entry valid; equals !empty.
- outReady  in  1  decode accepts the head; equals !stall of decode.
- instrD  out  XLEN  head instruction.
- pcD  out  XLEN  head pc.
- pcPlus4D  out  XLEN  head pc+4.
- bPredictedTakenD  out  1  head prediction.
- count  out  PTRW+1  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rstN low, asynchronous):
  - wrPtr, rdPtr and count go to 0.
  - Outputs become empty=1, full=0, outValid=0, inReady=1, count=0.
  - instrD, pcD, pcPlus4D and bPredictedTakenD read 0.
  - Storage array is not reset.
- Release from reset is synchronous to clk. A reset mid-operation drops all entries.
- Push = inValid & inReady & !flush. The packet is written at wrPtr and wrPtr increments modulo DEPTH.
- Pop = outValid & outReady & !flush. rdPtr increments modulo DEPTH.
- Head outputs are combinational from entry[rdPtr], masked to all-zero when empty. All-zero is a bubble, identical to the flushed pipeline register.
- Latency:
  - A packet pushed at edge N is visible on the head outputs after edge N.
  - There is no same-cycle fall-through from inputs to outputs.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Legal at any occupancy from 1 to DEPTH-1.
  - When full, inReady=0, so a push in the same cycle as a pop is refused. There is no combinational path from outReady to inReady.
- count update, non-flush cycles: count_next = count + push - pop.
- Overflow and underflow are impossible by construction. An assertion flags push while full and pop while empty.
- flush (synchronous, highest priority):
  - Next cycle: wrPtr=rdPtr=0, count=0, outValid=0.
  - Any push or pop in the flush cycle is ignored.
- Pointer wrap: pointers are PTRW bits and wrap DEPTH-1 -> 0. full and empty are derived from count, not from pointer compare.
- Head fields are held while outValid=1 and outReady=0, even if pushes occur. This is checked by assertion.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_pkt_t, a packed struct {instr, pc, pcPlus4, bPredictedTaken}, sized by XLEN.
  - constant NOP_PKT, all-zero.
- Storage is an array of fetch_pkt_t.
- One sub-module: queue_ptr_ctrl, holding the pointers, count and the push/pop/flush logic. The top level holds storage and the output mux.

Test Plan:
- Reset with rstN=0 mid-stream while count=3 -> count=0, outValid=0, instrD=0 immediately (asynchronous), inReady=1.
- Push four packets (pc=0x100/0x104/0x108/0x10C) with outReady=0 -> count=4, full=1, inReady=0, pcD=0x100 held throughout.
- Full queue, outReady=1 and inValid=1 for one cycle -> one pop, no push, count=3, pcD=0x104.
- Steady stream, push and pop every cycle from count=1 for 10 cycles -> count stays 1, pcD sequence matches pushed pc with 1-cycle latency, pointers wrap 3->0 twice.
- flush asserted with count=2 and inValid=1 (pc=0x200) -> next cycle count=0, outValid=0, 0x200 never appears on pcD.
- Push into an empty queue (instrF=0x00500093, bPredictedTakenF=1) -> outValid=0 that cycle, then 1 after the edge, with instrD=0x00500093 and bPredictedTakenD=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch-to-decode queue.
//   fetch_pkt_t : one fetch packet (instr, pc, pc+4, predictor decision)
//   NOP_PKT     : all-zero packet. It is the decode-side bubble.
package fetch_pkg;
  // Packet field width. The queue's XLEN parameter must match this value.
  localparam int FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] pc_plus4;
    logic                  b_predicted_taken;
  } fetch_pkt_t;

  localparam fetch_pkt_t NOP_PKT = '0;
endpackage

// File: rtl/queue_ptr_ctrl.sv
// Pointer, occupancy and handshake control for the fetch queue.
//   in:  clk, rst_n (async active-low), flush, in_valid, out_ready
//   out: push and pop (qualified transfers), in_ready, out_valid, full, empty,
//        wr_ptr and rd_ptr (PTRW bits, wrap modulo DEPTH), count (PTRW+1 bits)
module queue_ptr_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PTRW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            out_ready,
  output logic            push,
  output logic            pop,
  output logic            in_ready,
  output logic            out_valid,
  output logic            full,
  output logic            empty,
  output logic [PTRW-1:0] wr_ptr,
  output logic [PTRW-1:0] rd_ptr,
  output logic [PTRW:0]   count
);
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]   count_q, count_d;

  // full and empty come from count, so equal pointers are never ambiguous.
  // in_ready depends only on state, so outReady has no path to inReady.
  always_comb begin
    full      = (count_q == (PTRW+1)'(DEPTH));
    empty     = (count_q == '0);
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // DEPTH is a power of two, so a plain increment wraps DEPTH-1 -> 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTRW+1)'(1);
        2'b01:   count_d = count_q - (PTRW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
endmodule

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry fetch-to-decode queue. It replaces the single IF/ID register.
//   fetch side : inValid/inReady handshake carrying instrF, pcF, pcPlus4F and bPredictedTakenF
//   decode side: outValid/outReady handshake. The head entry drives instrD, pcD,
//                pcPlus4D and bPredictedTakenD combinationally. It reads all-zero when empty.
//   control    : flush empties the queue in one cycle and overrides push/pop.
//   status     : count, full, empty
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int PTRW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [XLEN-1:0] instrF,
  input  logic [XLEN-1:0] pcF,
  input  logic [XLEN-1:0] pcPlus4F,
  input  logic            bPredictedTakenF,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pcPlus4D,
  output logic            bPredictedTakenD,
  output logic [PTRW:0]   count,
  output logic            full,
  output logic            empty
);
  logic            push, pop;
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  fetch_pkt_t      wr_pkt, head;

  // Storage is not reset. Entries are only visible once count covers them.
  fetch_pkt_t mem_q [DEPTH];

  queue_ptr_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .rst_n     (rstN),
    .flush     (flush),
    .in_valid  (inValid),
    .out_ready (outReady),
    .push      (push),
    .pop       (pop),
    .in_ready  (inReady),
    .out_valid (outValid),
    .full      (full),
    .empty     (empty),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count)
  );

  always_comb begin
    wr_pkt.instr             = instrF;
    wr_pkt.pc                = pcF;
    wr_pkt.pc_plus4          = pcPlus4F;
    wr_pkt.b_predicted_taken = bPredictedTakenF;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= wr_pkt;
  end

  // The read side only looks at stored state, so there is no fall-through.
  // An empty queue presents the same bubble as a flushed pipeline register.
  always_comb begin
    head = empty ? NOP_PKT : mem_q[rd_ptr];
    instrD           = head.instr;
    pcD              = head.pc;
    pcPlus4D         = head.pc_plus4;
    bPredictedTakenD = head.b_predicted_taken;
  end

  a_head_hold: assert property (@(posedge clk) disable iff (!rstN)
    (outValid && !outReady && !flush) |=> (head == $past(head)));
endmodule
